// File: rtl/equalizer_cmul_pipe_pkg.sv
// Shared equalizer definitions: default datapath widths and the full-precision
// width rule used by the complex multiplier and its round/saturate stage.
package equalizer_cmul_pipe_pkg;

  localparam int A_W_DEF    = 16;
  localparam int B_W_DEF    = 16;
  localparam int OUT_W_DEF  = 16;
  localparam int SHIFT_DEF  = 15;
  localparam int USER_W_DEF = 1;
  localparam int CNT_W      = 16;

  // One extra bit above the product width absorbs the re/im add or subtract.
  function automatic int full_w(input int aw, input int bw);
    return aw + bw + 1;
  endfunction

endpackage

// File: rtl/equalizer_round_sat.sv
// Combinational round-half-up, arithmetic right shift and range reduction
// (clamp or wrap) of one full-precision component, with an overflow bit.
module equalizer_round_sat #(
  parameter int IN_W      = 33,
  parameter int SHIFT     = 15,
  parameter int OUT_WIDTH = 16,
  parameter bit SATURATE  = 1'b1
) (
  input  logic signed [IN_W-1:0]      din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        ovf
);

  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0] RND_C = (SHIFT > 0) ? ((IN_W+1)'(1) << RS) : (IN_W+1)'(0);
  localparam logic signed [IN_W:0] MAX_C = ((IN_W+1)'(1) << (OUT_WIDTH - 1)) - (IN_W+1)'(1);
  localparam logic signed [IN_W:0] MIN_C = ~MAX_C;

  logic signed [IN_W:0] ext_s;
  logic signed [IN_W:0] rounded_s;
  logic signed [IN_W:0] shifted_s;

  // Guard bit keeps the rounding add from overflowing.
  assign ext_s     = {din[IN_W-1], din};
  assign rounded_s = ext_s + RND_C;
  assign shifted_s = rounded_s >>> SHIFT;

  // Range check and clamp/wrap selection.
  always_comb begin
    ovf  = (shifted_s > MAX_C) || (shifted_s < MIN_C);
    dout = shifted_s[OUT_WIDTH-1:0];
    if (ovf && SATURATE) begin
      if (shifted_s < MIN_C) begin
        dout = MIN_C[OUT_WIDTH-1:0];
      end else begin
        dout = MAX_C[OUT_WIDTH-1:0];
      end
    end else begin
      dout = shifted_s[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/equalizer_cmul_pipe.sv
// Four-stage signed complex multiplier (a*b or a*conj(b)) with rounding,
// saturation or wrap, valid/sideband alignment, ce stall and overflow counter.
module equalizer_cmul_pipe
  import equalizer_cmul_pipe_pkg::*;
#(
  parameter int A_WIDTH    = A_W_DEF,
  parameter int B_WIDTH    = B_W_DEF,
  parameter int OUT_WIDTH  = OUT_W_DEF,
  parameter int SHIFT      = SHIFT_DEF,
  parameter bit SATURATE   = 1'b1,
  parameter int USER_WIDTH = USER_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         conj,
  input  logic signed [A_WIDTH-1:0]    a_re,
  input  logic signed [A_WIDTH-1:0]    a_im,
  input  logic signed [B_WIDTH-1:0]    b_re,
  input  logic signed [B_WIDTH-1:0]    b_im,
  input  logic [USER_WIDTH-1:0]        in_user,
  input  logic                         clear_count,
  output logic                         out_valid,
  output logic signed [OUT_WIDTH-1:0]  p_re,
  output logic signed [OUT_WIDTH-1:0]  p_im,
  output logic [USER_WIDTH-1:0]        out_user,
  output logic                         sat_flag,
  output logic [CNT_W-1:0]             sat_count
);

  localparam int FULL_W = full_w(A_WIDTH, B_WIDTH);

  logic                      s1_v_r, s2_v_r, s3_v_r;
  logic                      s1_conj_r, s2_conj_r;
  logic signed [A_WIDTH-1:0] s1_ar_r, s1_ai_r;
  logic signed [B_WIDTH-1:0] s1_br_r, s1_bi_r;
  logic [USER_WIDTH-1:0]     s1_user_r, s2_user_r, s3_user_r;
  logic signed [FULL_W-1:0]  pp_rr_r, pp_ii_r, pp_ir_r, pp_ri_r;
  logic signed [FULL_W-1:0]  s3_re_r, s3_im_r;
  logic signed [OUT_WIDTH-1:0] re_q_s, im_q_s;
  logic                      re_ovf_s, im_ovf_s, ovf_s;

  equalizer_round_sat #(.IN_W(FULL_W), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH), .SATURATE(SATURATE))
    u_rs_re (.din(s3_re_r), .dout(re_q_s), .ovf(re_ovf_s));
  equalizer_round_sat #(.IN_W(FULL_W), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH), .SATURATE(SATURATE))
    u_rs_im (.din(s3_im_r), .dout(im_q_s), .ovf(im_ovf_s));

  assign ovf_s = re_ovf_s | im_ovf_s;

  // Valid pipeline: shifts on every ce-high edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_r    <= 1'b0;
      s2_v_r    <= 1'b0;
      s3_v_r    <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      s1_v_r    <= in_valid;
      s2_v_r    <= s1_v_r;
      s3_v_r    <= s2_v_r;
      out_valid <= s3_v_r;
    end
  end

  // Data pipeline: each stage loads only for a valid incoming sample, so outputs hold across bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_conj_r <= 1'b0;
      s1_ar_r   <= '0;
      s1_ai_r   <= '0;
      s1_br_r   <= '0;
      s1_bi_r   <= '0;
      s1_user_r <= '0;
      s2_conj_r <= 1'b0;
      pp_rr_r   <= '0;
      pp_ii_r   <= '0;
      pp_ir_r   <= '0;
      pp_ri_r   <= '0;
      s2_user_r <= '0;
      s3_re_r   <= '0;
      s3_im_r   <= '0;
      s3_user_r <= '0;
      p_re      <= '0;
      p_im      <= '0;
      out_user  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (ce && in_valid) begin
        s1_conj_r <= conj;
        s1_ar_r   <= a_re;
        s1_ai_r   <= a_im;
        s1_br_r   <= b_re;
        s1_bi_r   <= b_im;
        s1_user_r <= in_user;
      end
      if (ce && s1_v_r) begin
        s2_conj_r <= s1_conj_r;
        pp_rr_r   <= FULL_W'(s1_ar_r) * FULL_W'(s1_br_r);
        pp_ii_r   <= FULL_W'(s1_ai_r) * FULL_W'(s1_bi_r);
        pp_ir_r   <= FULL_W'(s1_ai_r) * FULL_W'(s1_br_r);
        pp_ri_r   <= FULL_W'(s1_ar_r) * FULL_W'(s1_bi_r);
        s2_user_r <= s1_user_r;
      end
      if (ce && s2_v_r) begin
        s3_user_r <= s2_user_r;
        if (s2_conj_r) begin
          s3_re_r <= pp_rr_r + pp_ii_r;
          s3_im_r <= pp_ir_r - pp_ri_r;
        end else begin
          s3_re_r <= pp_rr_r - pp_ii_r;
          s3_im_r <= pp_ir_r + pp_ri_r;
        end
      end
      if (ce && s3_v_r) begin
        p_re     <= re_q_s;
        p_im     <= im_q_s;
        out_user <= s3_user_r;
        sat_flag <= ovf_s;
      end
    end
  end

  // Overflow counter: counts each overflowed result as it enters the output stage; clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_count <= '0;
    end else if (clear_count) begin
      sat_count <= '0;
    end else if (ce && s3_v_r && ovf_s && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end else begin
      sat_count <= sat_count;
    end
  end

endmodule

// File: tb/tb_equalizer_cmul_pipe.sv
// Directed bench for equalizer_cmul_pipe: saturating and wrapping instances
// driven in parallel, expected values computed by hand.
module tb_equalizer_cmul_pipe;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               ce;
  logic               in_valid;
  logic               conj;
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic [3:0]         in_user;
  logic               clear_count;

  logic               out_valid, w_out_valid;
  logic signed [15:0] p_re, p_im, w_p_re, w_p_im;
  logic [3:0]         out_user, w_out_user;
  logic               sat_flag, w_sat_flag;
  logic [15:0]        sat_count, w_sat_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  equalizer_cmul_pipe #(.USER_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .conj(conj),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .in_user(in_user),
    .clear_count(clear_count), .out_valid(out_valid), .p_re(p_re), .p_im(p_im),
    .out_user(out_user), .sat_flag(sat_flag), .sat_count(sat_count)
  );

  equalizer_cmul_pipe #(.USER_WIDTH(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .conj(conj),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .in_user(in_user),
    .clear_count(clear_count), .out_valid(w_out_valid), .p_re(w_p_re), .p_im(w_p_im),
    .out_user(w_out_user), .sat_flag(w_sat_flag), .sat_count(w_sat_count)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cj, input int ar, input int ai, input int br, input int bi);
    in_valid = 1'b1;
    conj     = cj;
    a_re     = 16'(ar);
    a_im     = 16'(ai);
    b_re     = 16'(br);
    b_im     = 16'(bi);
  endtask

  initial begin
    int tag;
    int got;
    int stale;
    logic ce_at_edge;
    logic v_at_edge;

    reset_n = 1'b0; ce = 1'b1; in_valid = 1'b0; conj = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; in_user = '0; clear_count = 1'b0;
    tick();
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_sat_count", int'(sat_count), 0);
    check_val("rst_p_re", int'(p_re), 0);
    reset_n = 1'b1;
    tick();

    // Basic: (100,-50)*(16384,8192) -> (63,0), visible exactly after the 4th edge
    drive(1'b0, 100, -50, 16384, 8192);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check_val("basic_not_early", int'(out_valid), 0);
    tick();
    check_val("basic_valid", int'(out_valid), 1);
    check_val("basic_p_re", int'(p_re), 63);
    check_val("basic_p_im", int'(p_im), 0);
    check_val("basic_sat_flag", int'(sat_flag), 0);

    // Corner: all -32768, conj -> re=2^31 overflows
    drive(1'b1, -32768, -32768, -32768, -32768);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check_val("corner_p_re", int'(p_re), 32767);
    check_val("corner_p_im", int'(p_im), 0);
    check_val("corner_sat_flag", int'(sat_flag), 1);
    check_val("wrap_p_re", int'(w_p_re), 0);
    check_val("wrap_sat_flag", int'(w_sat_flag), 1);
    tick();
    check_val("corner_sat_count", int'(sat_count), 1);
    check_val("wrap_sat_count", int'(w_sat_count), 1);

    // Rounding: -0.5 -> 0, +0.5 -> 1, back to back
    drive(1'b0, -1, 0, 16384, 0);
    tick();
    drive(1'b0, 1, 0, 16384, 0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check_val("round_neg_valid", int'(out_valid), 1);
    check_val("round_neg_half", int'(p_re), 0);
    tick();
    check_val("round_pos_valid", int'(out_valid), 1);
    check_val("round_pos_half", int'(p_re), 1);

    // Stall: ce toggles, 8 tagged samples must come out once each, in order
    tag = 0;
    got = 0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      ce       = (c % 2 == 0);
      in_valid = (tag < 8);
      conj     = 1'b0;
      a_re     = 16'(tag * 1000);
      a_im     = '0;
      b_re     = 16'sd16384;
      b_im     = '0;
      in_user  = 4'(tag);
      ce_at_edge = ce;
      v_at_edge  = in_valid;
      tick();
      if (ce_at_edge) begin
        if (v_at_edge) tag++;
        if (out_valid) begin
          check_val("stall_user", int'(out_user), got);
          check_val("stall_p_re", int'(p_re), got * 500);
          got++;
        end
      end
    end
    check_val("stall_count", got, 8);
    ce = 1'b1;
    in_valid = 1'b0;
    tick();
    check_val("stall_drained", int'(out_valid), 0);

    // Reset mid-stream with 3 samples in flight
    drive(1'b1, -32768, -32768, -32768, -32768);
    tick(); tick(); tick();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_val("midrst_out_valid", int'(out_valid), 0);
    check_val("midrst_sat_count", int'(sat_count), 0);
    check_val("midrst_p_re", int'(p_re), 0);
    tick();
    reset_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) stale++;
    end
    check_val("midrst_no_stale", stale, 0);

    // Counter: 0xFFFF+2 saturating results must hold at 0xFFFF
    drive(1'b1, -32768, -32768, -32768, -32768);
    repeat (65537) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check_val("count_hold", int'(sat_count), 65535);
    check_val("wrap_count_hold", int'(w_sat_count), 65535);

    // Clear coinciding with a saturating result
    drive(1'b1, -32768, -32768, -32768, -32768);
    repeat (5) tick();
    clear_count = 1'b1;
    tick();
    check_val("clear_priority", int'(sat_count), 0);
    clear_count = 1'b0;
    tick();
    check_val("count_after_clear", int'(sat_count), 1);
    in_valid = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/equalizer_cmul_pipe.md
# equalizer_cmul_pipe

Parametrised, fully pipelined signed complex multiplier for the equalizer datapath. It computes a·b or a·conj(b) per sample, then applies round-half-up right shift and saturation or wrap to a configurable output width. It carries a valid flag and a user sideband through a fixed 4-stage pipeline with global clock-enable stall, and keeps a sticky overflow counter. It replaces the fixed-width real scalar multipliers in channel-estimate and correction paths.

## Interface
- A_WIDTH, 16, signed width of a_re/a_im
- B_WIDTH, 16, signed width of b_re/b_im
- OUT_WIDTH, 16, signed width of p_re/p_im; must be ≤ A_WIDTH+B_WIDTH+1−SHIFT
- SHIFT, 15, arithmetic right shift after rounding; 0 disables rounding
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap (truncate)
- USER_WIDTH, 1, sideband width carried with each sample
- clk  in  1  rising-edge clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  global enable; low freezes every pipeline register
- in_valid  in  1  input sample valid
- conj  in  1  per-sample mode; 1 = multiply by conj(b)
- a_re, a_im  in  A_WIDTH  signed operand a
- b_re, b_im  in  B_WIDTH  signed operand b
- in_user  in  USER_WIDTH  sideband tag
- clear_count  in  1  synchronous clear of sat_count
- out_valid  out  1  result valid
- p_re, p_im  out  OUT_WIDTH  signed result
- out_user  out  USER_WIDTH  tag aligned with the result
- sat_flag  out  1  this result overflowed, in either component
- sat_count  out  16  number of overflowed results; saturates at 0xFFFF

## Operation
- FULL_W = A_WIDTH+B_WIDTH+1. All products and sums are signed at FULL_W.
- conj=0: re = ar·br − ai·bi, im = ai·br + ar·bi.
- conj=1: re = ar·br + ai·bi, im = ai·br − ar·bi.
- Round: add 2^(SHIFT−1) when SHIFT>0, then shift right arithmetically by SHIFT. The add uses one guard bit so it cannot overflow. Ties round toward +∞, so −0.5 becomes 0.
- Range check against [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]:
  - SATURATE=1: clamp to the nearest bound.
  - SATURATE=0: keep the low OUT_WIDTH bits.
  - sat_flag is set in both modes.
- Stages, each advancing only when ce=1:
  - S1: register inputs, conj and user.
  - S2: four partial products.
  - S3: re/im add or subtract.
  - S4: round/shift/saturate into the output registers.
- Valid shifts through all stages. Data registers of a stage load only when ce and that stage's incoming valid are both high. p_*, out_user and sat_flag therefore hold the last valid result during bubbles.
- sat_count:
  - Increments when ce && out_valid && sat_flag are all high in the output stage.
  - Holds at 0xFFFF.
  - clear_count has priority over an increment in the same cycle; the result is 0.
  - clear_count is independent of ce.

## Timing
- Latency is 4 ce-qualified rising edges. A sample accepted at edge k, with ce=1, appears with out_valid=1 after edge k+3 and is stable from then on. Full throughput: one sample per ce-high cycle.
- ce=0: all stages, valids and outputs hold. No sample is lost or duplicated.
- reset_n low: all valid bits, data registers, sat_flag and sat_count are cleared to 0 immediately, asynchronously. In-flight samples are discarded. The first output after release comes from a sample accepted after release.
- No back-pressure; downstream must accept every out_valid cycle.

## Structure
- The shared equalizer package holds FULL_W derivation, default widths, and the round/saturate function or its constants.
- One sub-module, equalizer_round_sat (combinational: round, shift, range check, clamp/wrap, overflow bit), instantiated twice for re and im in S4.

## Test plan
- Basic, with defaults: a=(100,−50), b=(16384,8192), conj=0 -> p=(63,0), sat_flag=0, out_valid exactly 4 edges later.
- Corner, with defaults: a=(−32768,−32768), b=(−32768,−32768), conj=1 -> p_re=32767, p_im=0, sat_flag=1, sat_count=1. With SATURATE=0 -> p_re=0 (wrap of 65536), sat_flag=1.
- Rounding: a=(−1,0), b=(16384,0) -> p_re=0. With a=(1,0) -> p_re=1.
- Stall: 8 back-to-back samples tagged 0..7, ce toggling every cycle -> 8 results in order with matching out_user, none lost or repeated, out_valid only in ce-high cycles.
- Reset mid-stream: reset_n low for 1 cycle with 3 samples in flight -> out_valid=0 and sat_count=0 immediately; no stale result after release.
- Counter: force 0xFFFF+2 saturating results -> sat_count holds 0xFFFF. clear_count in the same cycle as a saturating result -> sat_count=0.
